// File: rtl/toggle_window_counter.sv
// Toggle monitor: one-cycle rise/fall pulses plus a gated transition count
// taken over a fixed window of WINDOW clock edges after an accepted start.
module toggle_window_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int WIN_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig,
  input  logic             en,
  input  logic             start,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);

  state_t             state_q, state_d;
  logic               sig_q, sig_d;
  logic               primed_q, primed_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               trans;

  always_comb begin
    sig_d    = sig;
    primed_d = 1'b1;
    // primed masks the first edge so sig=1 out of reset is not seen as a rise
    trans    = primed_q & (sig ^ sig_q);
    rise_d   = primed_q & sig & ~sig_q;
    fall_d   = primed_q & ~sig & sig_q;

    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    win_d    = win_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MEASURE;
          count_d = '0;
          ovf_d   = 1'b0;
          win_d   = WIN_LOAD;
          busy_d  = 1'b1;
        end
      end
      MEASURE: begin
        if (trans && en) begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        // the edge that sees the window counter at zero is the last one counted
        if (win_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      sig_q    <= 1'b0;
      primed_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      primed_q <= primed_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      win_q    <= win_d;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_toggle_window_counter.sv
// Directed bench: a default instance, a 3-bit saturating instance and a
// WINDOW=1 instance share stimulus and are checked against hand-derived values.
module tb_toggle_window_counter;

  logic clock = 1'b0;
  logic reset, sig, en, start;

  logic       m_rise, m_fall, m_busy, m_done, m_ovf;
  logic [7:0] m_count;
  logic       s_rise, s_fall, s_busy, s_done, s_ovf;
  logic [2:0] s_count;
  logic       w_rise, w_fall, w_busy, w_done, w_ovf;
  logic [7:0] w_count;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  toggle_window_counter #(.CNT_W(8), .WINDOW(16), .WIN_W(16)) dut_main (
    .clock(clock), .reset(reset), .sig(sig), .en(en), .start(start),
    .rise(m_rise), .fall(m_fall), .busy(m_busy), .done(m_done),
    .count(m_count), .ovf(m_ovf)
  );

  toggle_window_counter #(.CNT_W(3), .WINDOW(16), .WIN_W(16)) dut_sat (
    .clock(clock), .reset(reset), .sig(sig), .en(en), .start(start),
    .rise(s_rise), .fall(s_fall), .busy(s_busy), .done(s_done),
    .count(s_count), .ovf(s_ovf)
  );

  toggle_window_counter #(.CNT_W(8), .WINDOW(1), .WIN_W(16)) dut_w1 (
    .clock(clock), .reset(reset), .sig(sig), .en(en), .start(start),
    .rise(w_rise), .fall(w_fall), .busy(w_busy), .done(w_done),
    .count(w_count), .ovf(w_ovf)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full window: start pulse, 16 measurement edges, then one edge in DONE.
  task automatic applyStimulus(input string tag, input int period, input int gateEdges,
                               input bit toggleAtStart, input int expMain,
                               input int expSat, input bit expSatOvf, input int expW1);
    logic prev;
    prev = sig;
    if (toggleAtStart) sig = ~sig;
    start = 1'b1;
    en    = 1'b1;
    step();
    start = 1'b0;
    checkOutput({tag, " start rise"}, 16'(m_rise), 16'(sig & ~prev));
    checkOutput({tag, " start fall"}, 16'(m_fall), 16'(~sig & prev));
    checkOutput({tag, " start busy"}, 16'(m_busy), 16'd1);
    checkOutput({tag, " start count"}, 16'(m_count), 16'd0);
    checkOutput({tag, " start sat count"}, 16'(s_count), 16'd0);
    checkOutput({tag, " start sat ovf"}, 16'(s_ovf), 16'd0);
    checkOutput({tag, " start w1 busy"}, 16'(w_busy), 16'd1);
    for (int m = 1; m <= 16; m++) begin
      prev = sig;
      if (period > 0 && (m % period) == 0) sig = ~sig;
      en = (m > gateEdges);
      step();
      checkOutput($sformatf("%s rise e%0d", tag, m), 16'(m_rise), 16'(sig & ~prev));
      checkOutput($sformatf("%s fall e%0d", tag, m), 16'(m_fall), 16'(~sig & prev));
      checkOutput($sformatf("%s busy e%0d", tag, m), 16'(m_busy), 16'(m < 16));
      checkOutput($sformatf("%s done e%0d", tag, m), 16'(m_done), 16'(m == 16));
      if (m == 1) begin
        checkOutput({tag, " w1 busy"}, 16'(w_busy), 16'd0);
        checkOutput({tag, " w1 done"}, 16'(w_done), 16'd1);
      end
      if (m == 2) checkOutput({tag, " w1 done clear"}, 16'(w_done), 16'd0);
    end
    checkOutput({tag, " count"}, 16'(m_count), 16'(expMain));
    checkOutput({tag, " ovf"}, 16'(m_ovf), 16'd0);
    checkOutput({tag, " sat count"}, 16'(s_count), 16'(expSat));
    checkOutput({tag, " sat ovf"}, 16'(s_ovf), 16'(expSatOvf));
    checkOutput({tag, " sat done"}, 16'(s_done), 16'd1);
    checkOutput({tag, " w1 count"}, 16'(w_count), 16'(expW1));
    en = 1'b1;
    step();
    checkOutput({tag, " post done"}, 16'(m_done), 16'd0);
    checkOutput({tag, " post busy"}, 16'(m_busy), 16'd0);
    checkOutput({tag, " post count"}, 16'(m_count), 16'(expMain));
  endtask

  initial begin
    bit doneSeen;
    reset = 1'b0;
    sig   = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    step();
    step();
    checkOutput("reset rise", 16'(m_rise), 16'd0);
    checkOutput("reset busy", 16'(m_busy), 16'd0);
    checkOutput("reset done", 16'(m_done), 16'd0);
    checkOutput("reset count", 16'(m_count), 16'd0);
    checkOutput("reset ovf", 16'(m_ovf), 16'd0);

    reset = 1'b1;
    step();
    checkOutput("first edge rise suppressed", 16'(m_rise), 16'd0);
    checkOutput("first edge fall", 16'(m_fall), 16'd0);
    step();
    step();
    checkOutput("steady rise", 16'(m_rise), 16'd0);

    applyStimulus("basic", 4, 0, 1'b0, 4, 4, 1'b0, 0);
    applyStimulus("gate", 4, 8, 1'b0, 2, 2, 1'b0, 0);
    applyStimulus("sat", 1, 0, 1'b0, 16, 7, 1'b1, 1);
    applyStimulus("edges", 16, 0, 1'b1, 1, 1, 1'b0, 0);

    // Start held high: ignored through MEASURE and DONE, taken again in IDLE.
    start = 1'b1;
    step();
    checkOutput("held start busy", 16'(m_busy), 16'd1);
    for (int m = 1; m <= 16; m++) begin
      step();
      checkOutput($sformatf("held busy e%0d", m), 16'(m_busy), 16'(m < 16));
      checkOutput($sformatf("held done e%0d", m), 16'(m_done), 16'(m == 16));
    end
    step();
    checkOutput("held idle busy", 16'(m_busy), 16'd0);
    checkOutput("held idle done", 16'(m_done), 16'd0);
    step();
    checkOutput("held restart busy", 16'(m_busy), 16'd1);
    checkOutput("held restart count", 16'(m_count), 16'd0);
    start = 1'b0;

    sig = ~sig;
    step();
    checkOutput("midreset count before", 16'(m_count), 16'd1);
    step();
    step();
    step();
    checkOutput("midreset busy before", 16'(m_busy), 16'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("midreset busy", 16'(m_busy), 16'd0);
    checkOutput("midreset count", 16'(m_count), 16'd0);
    checkOutput("midreset done", 16'(m_done), 16'd0);
    doneSeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_done) doneSeen = 1'b1;
    end
    checkOutput("midreset no done", 16'(doneSeen), 16'd0);
    checkOutput("midreset idle busy", 16'(m_busy), 16'd0);

    applyStimulus("after reset", 2, 0, 1'b0, 8, 7, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
